mac_csa_accum: RTL



---
 rtl/mac_csa_accum.sv | 97 +++++++++
 1 files changed

// File: rtl/mac_csa_accum.sv
// Carry-save multi-operand accumulator: NUM_IN operands per beat are folded into a
// redundant sum/carry pair, and a single carry-propagate add resolves each group.
module mac_csa_accum #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int ACC_WIDTH = 40,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic                    i_last,
  input  logic                    i_clear,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [ACC_WIDTH-1:0]    o_result,
  output logic [15:0]             o_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUT} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, carry_q, result_q;
  logic [ACC_WIDTH-1:0] csa_sum, csa_carry, operand_ext, majority;
  logic [15:0]          count_q;
  logic                 accept;

  assign o_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign o_valid  = (state_q == OUT);
  assign accept   = i_valid & o_ready & ~i_clear;
  assign o_result = result_q;
  assign o_count  = count_q;

  // Chain of 3:2 compressors seeded with the stored redundant pair; the carry
  // vector is kept pre-shifted and its MSB carry-out is dropped (mod 2^ACC_WIDTH).
  always_comb begin
    csa_sum     = sum_q;
    csa_carry   = carry_q;
    operand_ext = '0;
    majority    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (SIGNED)
        operand_ext = ACC_WIDTH'($signed(i_data[k*WIDTH +: WIDTH]));
      else
        operand_ext = ACC_WIDTH'(i_data[k*WIDTH +: WIDTH]);
      majority  = (csa_sum & csa_carry) | (csa_sum & operand_ext) | (csa_carry & operand_ext);
      csa_sum   = csa_sum ^ csa_carry ^ operand_ext;
      csa_carry = majority << 1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACCUM: if (accept) state_d = i_last ? RESOLVE : ACCUM;
        RESOLVE:     state_d = OUT;
        OUT:         if (i_ready) state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  // Clear wins over everything and leaves result_q holding the last resolved group.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else if (i_clear) begin
      sum_q   <= '0;
      carry_q <= '0;
      count_q <= '0;
    end else if (accept) begin
      sum_q   <= csa_sum;
      carry_q <= csa_carry;
      if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end else if (state_q == RESOLVE) begin
      result_q <= sum_q + carry_q;
    end else if ((state_q == OUT) && i_ready) begin
      sum_q   <= '0;
      carry_q <= '0;
      count_q <= '0;
    end
  end

endmodule
